hazard_pipeline_processor: RTL and testbench
============================================

# hazard_pipeline_processor

Parametrised successor of the five-stage (IF/ID/EX/MEM/WB) 20-bit pipelined processor. It adds configurable data/address/register-file widths, data forwarding, load-use stall detection, jump squash and a retire port for verification. It sits between the instruction memory and the data memory, both of which are combinational-read and external to the block.

## Interface
Parameters:
- DATA_WIDTH, 20, register and data-memory word width (≥12)
- ADDR_WIDTH, 20, width of the instruction and data address buses
- REG_ADDR_WIDTH, 4, register-file index width; 2**REG_ADDR_WIDTH registers, maximum 4
- FORWARDING, 1, 1 = EX/MEM and MEM/WB bypass; 0 = interlock (stall) on every RAW hazard

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high; clears PC, pipeline and register file
- InstrIn  in  20  instruction at InstrAddr, same cycle
- InstrAddr  out  ADDR_WIDTH  PC
- DataIn_Mem  in  DATA_WIDTH  read data for MemAddress, same cycle
- MemAddress  out  ADDR_WIDTH  data-memory address (MEM stage)
- MemWriteData  out  DATA_WIDTH  store data
- MemWriteEnable  out  1  store strobe, one cycle per STORE
- Stall  out  1  PC and IF/ID held this cycle
- WbValid  out  1  a register write retires this cycle
- WbAddr  out  REG_ADDR_WIDTH  retiring destination
- WbData  out  DATA_WIDTH  retiring value

## Operation
- Fields: op=[19:16], rd=[15:12], rs=[11:8], rt=[7:4], imm8=[7:0], imm12=[11:0]. Register indices use the low REG_ADDR_WIDTH bits.
- Opcodes:
  - 0000 ADD rd=rs+rt
  - 0001 SUB rd=rs-rt
  - 0010 AND rd=rs&rt
  - 0011 NOT rd=~rs
  - 0100 LI rd=zext(imm8)
  - 1011 LOAD rd=mem[rs]
  - 1100 STORE mem[rs]=rt
  - 1110 JMP PC=zext(imm12)
  - Every other opcode is a NOP.
- Arithmetic wraps modulo 2**DATA_WIDTH. Addresses are rs truncated or zero-extended to ADDR_WIDTH. PC+1 wraps at 2**ADDR_WIDTH.
- Each pipeline register carries a valid bit. Invalid stages (bubbles) never write the register file or memory.
- The register file is write-first: a WB write to a register read in ID in the same cycle returns the new value.
- FORWARDING=1:
  - EX operands are taken from EX/MEM (ALU/LI result) first, then MEM/WB (ALU or load data), then the ID/EX value.
  - Load-use: the ID instruction reads the rd of a valid LOAD in EX. Stall=1 for one cycle: PC and IF/ID hold, and a bubble enters EX.
- FORWARDING=0: Stall=1 while any valid EX or MEM instruction writes a register that the ID instruction reads. WB is covered by the write-first register file.
- Source usage:
  - rs is read by ADD, SUB, AND, NOT, LOAD and STORE.
  - rt is read by ADD, SUB, AND and STORE.
  - Unused fields never cause a hazard.
- JMP is resolved in ID. The PC loads the target at the next edge and the IF/ID content fetched that cycle is squashed (one bubble).
- Stall and JMP in ID in the same cycle: the stall wins and the jump is taken when the stall releases.

## Timing
- Reset values: all of InstrAddr, MemAddress, MemWriteData, MemWriteEnable, Stall, WbValid, WbAddr, WbData = 0. All valid bits and registers = 0.
- Reset deasserted mid-operation: fetch restarts at address 0 on the first rising edge after release.
- Stage timing without stalls, for an instruction fetched in cycle n:
  - ID in cycle n+1
  - EX in cycle n+2
  - MEM in cycle n+3: MemWriteEnable for STORE, DataIn_Mem sampled for LOAD
  - WB in cycle n+4: WbValid=1, register written at the closing edge
- Each stall cycle delays every later instruction by exactly one cycle. Instructions ahead of the stall proceed unaffected.
- Back-to-back dependent ALU ops with FORWARDING=1: zero stall cycles.
- With FORWARDING=0, a dependency on the immediately preceding instruction costs 2 stall cycles; distance 2 costs 1; distance ≥3 costs 0.
- MemAddress and MemWriteData hold their last value when MemWriteEnable=0. Only MemWriteEnable is qualified.

## Test plan
- Reset: assert Reset mid-run for 1 cycle → all outputs 0 immediately, without waiting for Clock. After release, InstrAddr steps 0,1,2...
- Forwarding: LI r1,5; LI r2,7; ADD r3,r1,r2 (FORWARDING=1) → Stall never high, WbAddr=3 with WbData=12 four cycles after ADD fetch. Same program with FORWARDING=0 → Stall high 2 cycles, r3=12.
- Load-use: LI r4,0x10; LOAD r5,[r4] with DataIn_Mem=3; ADD r6,r5,r5 → exactly 1 Stall cycle, WbData=3 for r5 then 6 for r6.
- Store: LI r1,5; LI r4,0x10; STORE [r4],r1 → MemWriteEnable=1 for exactly one cycle with MemAddress=0x10 and MemWriteData=5. WbValid stays 0 for the store.
- Jump: JMP 0x040 at address 2 → InstrAddr sequence 0,1,2,3,0x40,0x41. The instruction at address 3 never produces WbValid.
- Wrap: LI r1,0; LI r2,1; SUB r3,r1,r2 → WbData = all ones (0xFFFFF for DATA_WIDTH=20). PC reaching 2**ADDR_WIDTH-1 wraps to 0.

Source files
------------

// File: rtl/hazard_pipeline_processor.sv
// Five-stage IF/ID/EX/MEM/WB processor with parametrised widths, EX/MEM and
// MEM/WB forwarding (or full interlock), load-use stall and jump squash.
module hazard_pipeline_processor #(
  parameter int DATA_WIDTH     = 20,
  parameter int ADDR_WIDTH     = 20,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int FORWARDING     = 1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [19:0]               InstrIn,
  output logic [ADDR_WIDTH-1:0]     InstrAddr,
  input  logic [DATA_WIDTH-1:0]     DataIn_Mem,
  output logic [ADDR_WIDTH-1:0]     MemAddress,
  output logic [DATA_WIDTH-1:0]     MemWriteData,
  output logic                      MemWriteEnable,
  output logic                      Stall,
  output logic                      WbValid,
  output logic [REG_ADDR_WIDTH-1:0] WbAddr,
  output logic [DATA_WIDTH-1:0]     WbData
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_NOT   = 4'b0011;
  localparam logic [3:0] OP_LI    = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b1011;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_JMP   = 4'b1110;
  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  function automatic logic writesReg(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_NOT) || (op == OP_LI) || (op == OP_LOAD);
  endfunction

  logic [ADDR_WIDTH-1:0]     pc;
  logic                      ifIdValid;
  logic [19:0]               ifIdInstr;

  logic [3:0]                idOp;
  logic [REG_ADDR_WIDTH-1:0] idRd, idRs, idRt;
  logic                      idReadsRs, idReadsRt, idJump;
  logic [DATA_WIDTH-1:0]     idRsVal, idRtVal;
  logic                      loadUse, exHit, memHit;

  logic                      idExValid;
  logic [3:0]                idExOp;
  logic [REG_ADDR_WIDTH-1:0] idExRd, idExRs, idExRt;
  logic [DATA_WIDTH-1:0]     idExRsVal, idExRtVal;
  logic [7:0]                idExImm;
  logic [DATA_WIDTH-1:0]     exA, exB, exResult;

  logic                      exMemValid;
  logic [3:0]                exMemOp;
  logic [REG_ADDR_WIDTH-1:0] exMemRd;
  logic [DATA_WIDTH-1:0]     exMemResult, exMemStoreData;
  logic [ADDR_WIDTH-1:0]     exMemAddr;

  logic                      memWbValid;
  logic [REG_ADDR_WIDTH-1:0] memWbRd;
  logic [DATA_WIDTH-1:0]     memWbData;

  logic [DATA_WIDTH-1:0]     regFile [NUM_REGS];

  assign idOp      = ifIdInstr[19:16];
  assign idRd      = ifIdInstr[12 +: REG_ADDR_WIDTH];
  assign idRs      = ifIdInstr[8 +: REG_ADDR_WIDTH];
  assign idRt      = ifIdInstr[4 +: REG_ADDR_WIDTH];
  assign idReadsRs = (idOp == OP_ADD) || (idOp == OP_SUB) || (idOp == OP_AND) ||
                     (idOp == OP_NOT) || (idOp == OP_LOAD) || (idOp == OP_STORE);
  assign idReadsRt = (idOp == OP_ADD) || (idOp == OP_SUB) || (idOp == OP_AND) ||
                     (idOp == OP_STORE);
  assign idJump    = ifIdValid && (idOp == OP_JMP);

  // Write-first register file: the retiring value is visible to ID this cycle.
  assign idRsVal = (memWbValid && memWbRd == idRs) ? memWbData : regFile[idRs];
  assign idRtVal = (memWbValid && memWbRd == idRt) ? memWbData : regFile[idRt];

  assign loadUse = idExValid && (idExOp == OP_LOAD) &&
                   ((idReadsRs && idExRd == idRs) || (idReadsRt && idExRd == idRt));
  assign exHit   = idExValid && writesReg(idExOp) &&
                   ((idReadsRs && idExRd == idRs) || (idReadsRt && idExRd == idRt));
  assign memHit  = exMemValid && writesReg(exMemOp) &&
                   ((idReadsRs && exMemRd == idRs) || (idReadsRt && exMemRd == idRt));
  assign Stall   = ifIdValid && ((FORWARDING != 0) ? loadUse : (exHit || memHit));

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    exA = idExRsVal;
    exB = idExRtVal;
    if (FORWARDING != 0) begin
      // A LOAD in EX/MEM has no data yet; the load-use stall keeps consumers out of EX.
      if (exMemValid && writesReg(exMemOp) && exMemOp != OP_LOAD && exMemRd == idExRs)
        exA = exMemResult;
      else if (memWbValid && memWbRd == idExRs)
        exA = memWbData;
      if (exMemValid && writesReg(exMemOp) && exMemOp != OP_LOAD && exMemRd == idExRt)
        exB = exMemResult;
      else if (memWbValid && memWbRd == idExRt)
        exB = memWbData;
    end
    unique case (idExOp)
      OP_ADD:  exResult = exA + exB;
      OP_SUB:  exResult = exA - exB;
      OP_AND:  exResult = exA & exB;
      OP_NOT:  exResult = ~exA;
      OP_LI:   exResult = DATA_WIDTH'(idExImm);
      default: exResult = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every stage samples the previous-cycle values of the others.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc        <= '0;
      ifIdValid <= 1'b0;
      ifIdInstr <= '0;
      idExValid <= 1'b0;
      idExOp    <= '0;
      idExRd    <= '0;
      idExRs    <= '0;
      idExRt    <= '0;
      idExRsVal <= '0;
      idExRtVal <= '0;
      idExImm   <= '0;
    end else begin
      // A stall holds the jump in ID; it is taken once the stall releases.
      if (!Stall) begin
        if (idJump) begin
          pc        <= ADDR_WIDTH'(ifIdInstr[11:0]);
          ifIdValid <= 1'b0;
        end else begin
          pc        <= pc + ADDR_WIDTH'(1);
          ifIdValid <= 1'b1;
          ifIdInstr <= InstrIn;
        end
      end
      idExValid <= ifIdValid && !Stall && !idJump;
      idExOp    <= idOp;
      idExRd    <= idRd;
      idExRs    <= idRs;
      idExRt    <= idRt;
      idExRsVal <= idRsVal;
      idExRtVal <= idRtVal;
      idExImm   <= ifIdInstr[7:0];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      exMemValid     <= 1'b0;
      exMemOp        <= '0;
      exMemRd        <= '0;
      exMemResult    <= '0;
      exMemAddr      <= '0;
      exMemStoreData <= '0;
      memWbValid     <= 1'b0;
      memWbRd        <= '0;
      memWbData      <= '0;
    end else begin
      exMemValid  <= idExValid;
      exMemOp     <= idExOp;
      exMemRd     <= idExRd;
      exMemResult <= exResult;
      // Memory address and store data only move for memory ops, so they hold otherwise.
      if (idExValid && (idExOp == OP_LOAD || idExOp == OP_STORE))
        exMemAddr <= ADDR_WIDTH'(exA);
      if (idExValid && idExOp == OP_STORE)
        exMemStoreData <= exB;
      memWbValid <= exMemValid && writesReg(exMemOp);
      memWbRd    <= exMemRd;
      memWbData  <= (exMemOp == OP_LOAD) ? DataIn_Mem : exMemResult;
    end
  end

  // NOTE: the register file is reset explicitly because the architecture defines every register as 0 after reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else if (memWbValid) begin
      regFile[memWbRd] <= memWbData;
    end
  end

  assign InstrAddr      = pc;
  assign MemAddress     = exMemAddr;
  assign MemWriteData   = exMemStoreData;
  assign MemWriteEnable = exMemValid && (exMemOp == OP_STORE);
  assign WbValid        = memWbValid;
  assign WbAddr         = memWbRd;
  assign WbData         = memWbData;

endmodule

// File: tb/tb_hazard_pipeline_processor.sv
// Bench for hazard_pipeline_processor: forwarding and interlock instances run
// the same programs; retirements are scored against expected queues.
module tb_hazard_pipeline_processor;

  localparam logic [19:0] NOP = 20'hF0000;

  typedef struct {
    logic [3:0]  addr;
    logic [19:0] data;
    int          cycle;
  } wbExp_t;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] exp;
    bit          hasWb;
    int          stallsN;
  } aluVec_t;

  logic        Clock, Reset;
  logic [19:0] imem [256];
  logic [19:0] dmem [256];

  logic [19:0] instrF, addrF, dinF, maF, mdF, wdF;
  logic        weF, stF, wvF;
  logic [3:0]  waF;
  logic [19:0] instrN, addrN, dinN, maN, mdN, wdN;
  logic        weN, stN, wvN;
  logic [3:0]  waN;
  logic [3:0]  addrW, maW, waW;
  logic [19:0] mdW, wdW;
  logic        weW, stW, wvW;

  assign instrF = (addrF < 20'd256) ? imem[addrF[7:0]] : NOP;
  assign instrN = (addrN < 20'd256) ? imem[addrN[7:0]] : NOP;
  assign dinF   = dmem[maF[7:0]];
  assign dinN   = dmem[maN[7:0]];

  hazard_pipeline_processor #(.FORWARDING(1)) dutF (
    .Clock(Clock), .Reset(Reset), .InstrIn(instrF), .InstrAddr(addrF),
    .DataIn_Mem(dinF), .MemAddress(maF), .MemWriteData(mdF),
    .MemWriteEnable(weF), .Stall(stF), .WbValid(wvF), .WbAddr(waF), .WbData(wdF));

  hazard_pipeline_processor #(.FORWARDING(0)) dutN (
    .Clock(Clock), .Reset(Reset), .InstrIn(instrN), .InstrAddr(addrN),
    .DataIn_Mem(dinN), .MemAddress(maN), .MemWriteData(mdN),
    .MemWriteEnable(weN), .Stall(stN), .WbValid(wvN), .WbAddr(waN), .WbData(wdN));

  hazard_pipeline_processor #(.ADDR_WIDTH(4), .FORWARDING(1)) dutW (
    .Clock(Clock), .Reset(Reset), .InstrIn(NOP), .InstrAddr(addrW),
    .DataIn_Mem(20'h0), .MemAddress(maW), .MemWriteData(mdW),
    .MemWriteEnable(weW), .Stall(stW), .WbValid(wvW), .WbAddr(waW), .WbData(wdW));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int     checks = 0;
  int     passes = 0;
  wbExp_t qF[$];
  wbExp_t qN[$];
  int     stallCnt [2];
  int     weCnt [2];
  logic [19:0] addrHist [2][64];
  logic [19:0] expStoreAddr, expStoreData;
  aluVec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  function automatic logic [19:0] li(input logic [3:0] rd, input logic [7:0] imm);
    return {4'h4, rd, 4'h0, imm};
  endfunction

  task automatic expectBoth(input logic [3:0] a, input logic [19:0] d, input int cF, input int cN);
    qF.push_back('{a, d, cF});
    qN.push_back('{a, d, cN});
  endtask

  task automatic observe(input int idx, input int cyc, input logic st, input logic wv,
                         input logic [3:0] wa, input logic [19:0] wd, input logic we,
                         input logic [19:0] ma, input logic [19:0] md);
    wbExp_t e;
    bit     have;
    if (st) stallCnt[idx]++;
    if (we) begin
      weCnt[idx]++;
      check($sformatf("store_addr dut%0d", idx), 32'(ma), 32'(expStoreAddr));
      check($sformatf("store_data dut%0d", idx), 32'(md), 32'(expStoreData));
    end
    if (wv) begin
      have = (idx == 0) ? (qF.size() > 0) : (qN.size() > 0);
      if (!have) begin
        checks++;
        $display("FAIL unexpected_retire dut%0d cycle %0d: got r%0d=%0h, required no retirement",
                 idx, cyc, wa, wd);
      end else begin
        e = (idx == 0) ? qF.pop_front() : qN.pop_front();
        check($sformatf("wb_addr dut%0d", idx), 32'(wa), 32'(e.addr));
        check($sformatf("wb_data dut%0d r%0d", idx, e.addr), 32'(wd), 32'(e.data));
        if (e.cycle >= 0)
          check($sformatf("wb_cycle dut%0d r%0d", idx, e.addr), 32'(cyc), 32'(e.cycle));
      end
    end
  endtask

  task automatic startProgram();
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem[i] = NOP;
      dmem[i] = 20'h0;
    end
    qF.delete();
    qN.delete();
    for (int i = 0; i < 2; i++) begin
      stallCnt[i] = 0;
      weCnt[i]    = 0;
    end
  endtask

  task automatic runCycles(input int n, input bit drain);
    @(negedge Clock);
    Reset = 1'b0;
    addrHist[0][0] = addrF;
    addrHist[1][0] = addrN;
    for (int c = 1; c <= n; c++) begin
      @(negedge Clock);
      if (c < 64) begin
        addrHist[0][c] = addrF;
        addrHist[1][c] = addrN;
      end
      observe(0, c, stF, wvF, waF, wdF, weF, maF, mdF);
      observe(1, c, stN, wvN, waN, wdN, weN, maN, mdN);
    end
    if (drain) begin
      check("retired_all dut0", 32'(qF.size()), 32'd0);
      check("retired_all dut1", 32'(qN.size()), 32'd0);
    end
  endtask

  task automatic checkCounts(input string name, input int sF, input int sN, input int wF, input int wN);
    check({name, " stalls dut0"}, 32'(stallCnt[0]), 32'(sF));
    check({name, " stalls dut1"}, 32'(stallCnt[1]), 32'(sN));
    check({name, " stores dut0"}, 32'(weCnt[0]), 32'(wF));
    check({name, " stores dut1"}, 32'(weCnt[1]), 32'(wN));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] jumpSeq [6];
    jumpSeq[0] = 20'h0;  jumpSeq[1] = 20'h1;  jumpSeq[2] = 20'h2;
    jumpSeq[3] = 20'h3;  jumpSeq[4] = 20'h40; jumpSeq[5] = 20'h41;

    vecs[0] = '{4'h0, 4'd1, 4'd2, 8'h05, 8'h07, 20'h0000C, 1'b1, 2};
    vecs[1] = '{4'h1, 4'd1, 4'd2, 8'h00, 8'h01, 20'hFFFFF, 1'b1, 2};
    vecs[2] = '{4'h2, 4'd1, 4'd2, 8'hF0, 8'h3C, 20'h00030, 1'b1, 2};
    vecs[3] = '{4'h3, 4'd2, 4'd0, 8'h55, 8'h0F, 20'hFFFF0, 1'b1, 2};
    vecs[4] = '{4'h3, 4'd1, 4'd0, 8'hAA, 8'h01, 20'hFFF55, 1'b1, 1};
    vecs[5] = '{4'h0, 4'd1, 4'd2, 8'hFF, 8'hFF, 20'h001FE, 1'b1, 2};
    vecs[6] = '{4'h1, 4'd1, 4'd2, 8'h03, 8'h05, 20'hFFFFE, 1'b1, 2};
    vecs[7] = '{4'h5, 4'd1, 4'd2, 8'h11, 8'h22, 20'h00000, 1'b0, 0};
    expStoreAddr = 20'h0;
    expStoreData = 20'h0;

    startProgram();
    #1;
    check("reset InstrAddr dut0", 32'(addrF), 32'd0);
    check("reset Stall dut0", 32'(stF), 32'd0);
    check("reset WbValid dut0", 32'(wvF), 32'd0);

    // ALU table: LI r1,a; LI r2,b; OP r3,rs,rt
    foreach (vecs[v]) begin
      startProgram();
      imem[0] = li(4'd1, vecs[v].a);
      imem[1] = li(4'd2, vecs[v].b);
      imem[2] = {vecs[v].op, 4'd3, vecs[v].rs, vecs[v].rt, 4'h0};
      expectBoth(4'd1, 20'(vecs[v].a), 4, 4);
      expectBoth(4'd2, 20'(vecs[v].b), 5, 5);
      if (vecs[v].hasWb) expectBoth(4'd3, vecs[v].exp, 6, 6 + vecs[v].stallsN);
      runCycles(16, 1'b1);
      checkCounts($sformatf("alu%0d", v), 0, vecs[v].stallsN, 0, 0);
    end

    // Load-use: LI r4,0x10; LOAD r5,[r4]; ADD r6,r5,r5
    startProgram();
    dmem[8'h10] = 20'h3;
    imem[0] = li(4'd4, 8'h10);
    imem[1] = {4'hB, 4'd5, 4'd4, 4'h0, 4'h0};
    imem[2] = {4'h0, 4'd6, 4'd5, 4'd5, 4'h0};
    qF.push_back('{4'd4, 20'h10, 4});
    qF.push_back('{4'd5, 20'h3, 5});
    qF.push_back('{4'd6, 20'h6, 7});
    qN.push_back('{4'd4, 20'h10, 4});
    qN.push_back('{4'd5, 20'h3, 7});
    qN.push_back('{4'd6, 20'h6, 10});
    runCycles(16, 1'b1);
    checkCounts("loaduse", 1, 4, 0, 0);

    // Store: LI r1,5; LI r4,0x10; STORE [r4],r1
    startProgram();
    imem[0] = li(4'd1, 8'h05);
    imem[1] = li(4'd4, 8'h10);
    imem[2] = {4'hC, 4'h0, 4'd4, 4'd1, 4'h0};
    expStoreAddr = 20'h10;
    expStoreData = 20'h5;
    expectBoth(4'd1, 20'h5, 4, 4);
    expectBoth(4'd4, 20'h10, 5, 5);
    runCycles(16, 1'b1);
    checkCounts("store", 0, 2, 1, 1);
    check("store addr hold dut0", 32'(maF), 32'h10);
    check("store data hold dut1", 32'(mdN), 32'h5);

    // Jump: JMP 0x040 at address 2 squashes address 3
    startProgram();
    imem[0]    = li(4'd1, 8'h01);
    imem[1]    = li(4'd2, 8'h02);
    imem[2]    = {4'hE, 16'h0040};
    imem[3]    = li(4'd7, 8'h09);
    imem[8'h40] = li(4'd3, 8'h03);
    expectBoth(4'd1, 20'h1, 4, 4);
    expectBoth(4'd2, 20'h2, 5, 5);
    expectBoth(4'd3, 20'h3, 8, 8);
    runCycles(16, 1'b1);
    checkCounts("jump", 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("jump pc[%0d] dut0", k), 32'(addrHist[0][k]), 32'(jumpSeq[k]));
      check($sformatf("jump pc[%0d] dut1", k), 32'(addrHist[1][k]), 32'(jumpSeq[k]));
    end

    // Mid-run reset between clock edges, then restart and PC wrap
    startProgram();
    imem[0] = li(4'd1, 8'h05);
    imem[1] = li(4'd4, 8'h10);
    imem[2] = {4'hC, 4'h0, 4'd4, 4'd1, 4'h0};
    expectBoth(4'd1, 20'h5, 4, 4);
    runCycles(4, 1'b0);
    check("pre-reset WbValid dut0", 32'(wvF), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("async InstrAddr dut0", 32'(addrF), 32'd0);
    check("async WbValid dut0", 32'(wvF), 32'd0);
    check("async WbAddr dut0", 32'(waF), 32'd0);
    check("async WbData dut0", 32'(wdF), 32'd0);
    check("async Stall dut1", 32'(stN), 32'd0);
    check("async WbValid dut1", 32'(wvN), 32'd0);
    check("async WbData dut1", 32'(wdN), 32'd0);
    check("async InstrAddr dut1", 32'(addrN), 32'd0);
    check("async MemAddress dut0", 32'(maF), 32'd0);
    check("async MemWriteData dut0", 32'(mdF), 32'd0);
    check("async MemWriteEnable dut0", 32'(weF), 32'd0);
    check("async InstrAddr wrap", 32'(addrW), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    check("restart pc0 dut0", 32'(addrF), 32'd0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge Clock);
      if (k <= 2) check($sformatf("restart pc%0d dut0", k), 32'(addrF), 32'(k));
      if (k == 15) check("wrap pc top", 32'(addrW), 32'd15);
      if (k == 16) check("wrap pc zero", 32'(addrW), 32'd0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
